// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control-token symbols, alignment FSM states and the
// decoded-symbol payload passed from the symbol decoder to the alignment logic.
package tmds_pkg;

  localparam int unsigned SYM_W  = 10;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned CTRL_W = 2;

  // Control-period tokens, indexed by {C1,C0}; also used by tmds_encoder_dvi
  localparam logic [SYM_W-1:0] TOK_C00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_C01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_C10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_C11 = 10'b1010101011;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_SLIP   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
    logic              is_token;
  } sym_dec_t;

  // Counter width able to hold max_val, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decoder: recognises the four control tokens and
// undoes the XOR/XNOR transition coding and optional inversion of data symbols.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] i_sym,
  output sym_dec_t         o_dec_c
);

  logic [DATA_W-1:0] w_d;

  always_comb begin
    w_d = i_sym[9] ? ~i_sym[7:0] : i_sym[7:0];

    o_dec_c          = '0;
    o_dec_c.data[0]  = w_d[0];
    for (int i = 1; i < DATA_W; i++) begin
      o_dec_c.data[i] = i_sym[8] ? (w_d[i] ^ w_d[i-1]) : ~(w_d[i] ^ w_d[i-1]);
    end

    o_dec_c.is_token = 1'b1;
    case (i_sym)
      TOK_C00: o_dec_c.ctrl = 2'b00;
      TOK_C01: o_dec_c.ctrl = 2'b01;
      TOK_C10: o_dec_c.ctrl = 2'b10;
      TOK_C11: o_dec_c.ctrl = 2'b11;
      default: o_dec_c.is_token = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_decoder_dvi.sv
// DVI TMDS channel receiver: hunts for word alignment using control-token runs,
// requests bit slips from the deserializer, and decodes symbols with 2-cycle latency.
module tmds_decoder_dvi
  import tmds_pkg::*;
#(
  parameter int unsigned SEARCH_LEN  = 4096,
  parameter int unsigned SLIP_WAIT   = 16,
  parameter int unsigned LOCK_TOKENS = 8,
  parameter int unsigned LOSS_LIMIT  = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [SYM_W-1:0]  i_tmds,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_de,
  output logic              o_locked,
  output logic              o_bitslip
);

  localparam int unsigned SEARCH_W = cnt_w(SEARCH_LEN - 1);
  localparam int unsigned RUN_W    = cnt_w(LOCK_TOKENS);
  localparam int unsigned WAIT_W   = cnt_w(SLIP_WAIT - 1);
  localparam int unsigned LOSS_W   = cnt_w(LOSS_LIMIT - 1);

  localparam logic [SEARCH_W-1:0] SEARCH_LAST = SEARCH_W'(SEARCH_LEN - 1);
  localparam logic [RUN_W-1:0]    RUN_MAX     = RUN_W'(LOCK_TOKENS);
  localparam logic [RUN_W-1:0]    RUN_LAST    = RUN_W'(LOCK_TOKENS - 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [LOSS_W-1:0]   LOSS_LAST   = LOSS_W'(LOSS_LIMIT - 1);

  logic                r_rst_meta;
  logic                r_rst_sync;
  logic [SYM_W-1:0]    r_sym;
  sym_dec_t            w_dec;

  state_e              r_state;
  state_e              w_state_nxt;
  logic [SEARCH_W-1:0] r_search;
  logic [SEARCH_W-1:0] w_search_nxt;
  logic [RUN_W-1:0]    r_run;
  logic [RUN_W-1:0]    w_run_nxt;
  logic [WAIT_W-1:0]   r_wait;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic [LOSS_W-1:0]   r_loss;
  logic [LOSS_W-1:0]   w_loss_nxt;
  logic                w_locked_nxt;

  logic [DATA_W-1:0]   r_data;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_de;
  logic                r_locked;
  logic                r_bitslip;

  // Reset bridge: assertion propagates immediately, release is aligned to i_clk
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rst_meta <= 1'b1;
      r_rst_sync <= 1'b1;
    end else begin
      r_rst_meta <= 1'b0;
      r_rst_sync <= r_rst_meta;
    end
  end

  always_ff @(posedge i_clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_sym <= '0;
    end else begin
      r_sym <= i_tmds;
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .i_sym   (r_sym),
    .o_dec_c (w_dec)
  );

  always_ff @(posedge i_clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_state  <= ST_SEARCH;
      r_search <= '0;
      r_run    <= '0;
      r_wait   <= '0;
      r_loss   <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_search <= w_search_nxt;
      r_run    <= w_run_nxt;
      r_wait   <= w_wait_nxt;
      r_loss   <= w_loss_nxt;
    end
  end

  // Alignment FSM; a completed token run wins over search-window expiry
  always_comb begin
    w_state_nxt  = r_state;
    w_search_nxt = r_search;
    w_run_nxt    = r_run;
    w_wait_nxt   = r_wait;
    w_loss_nxt   = r_loss;

    case (r_state)
      ST_SEARCH: begin
        w_search_nxt = (r_search == SEARCH_LAST) ? r_search : r_search + SEARCH_W'(1);
        if (w_dec.is_token) begin
          w_run_nxt = (r_run == RUN_MAX) ? r_run : r_run + RUN_W'(1);
        end else begin
          w_run_nxt = '0;
        end
        if (w_dec.is_token && (r_run == RUN_LAST)) begin
          w_state_nxt = ST_LOCKED;
          w_loss_nxt  = '0;
        end else if (r_search == SEARCH_LAST) begin
          w_state_nxt = ST_SLIP;
        end
      end
      ST_SLIP: begin
        w_state_nxt = ST_WAIT;
        w_wait_nxt  = '0;
      end
      ST_WAIT: begin
        if (r_wait == WAIT_LAST) begin
          w_state_nxt  = ST_SEARCH;
          w_search_nxt = '0;
          w_run_nxt    = '0;
        end else begin
          w_wait_nxt = r_wait + WAIT_W'(1);
        end
      end
      ST_LOCKED: begin
        if (w_dec.is_token) begin
          w_loss_nxt = '0;
        end else if (r_loss == LOSS_LAST) begin
          w_state_nxt  = ST_SEARCH;
          w_search_nxt = '0;
          w_run_nxt    = '0;
        end else begin
          w_loss_nxt = r_loss + LOSS_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_SEARCH;
      end
    endcase

    w_locked_nxt = (w_state_nxt == ST_LOCKED);
  end

  // Output stage qualified by the lock state taking effect on this same edge
  always_ff @(posedge i_clk or posedge r_rst_sync) begin
    if (r_rst_sync) begin
      r_data    <= '0;
      r_ctrl    <= '0;
      r_de      <= 1'b0;
      r_locked  <= 1'b0;
      r_bitslip <= 1'b0;
    end else begin
      r_locked  <= w_locked_nxt;
      r_bitslip <= (w_state_nxt == ST_SLIP);
      if (!w_locked_nxt) begin
        r_data <= '0;
        r_ctrl <= '0;
        r_de   <= 1'b0;
      end else if (w_dec.is_token) begin
        r_de   <= 1'b0;
        r_ctrl <= w_dec.ctrl;
      end else begin
        r_de   <= 1'b1;
        r_data <= w_dec.data;
      end
    end
  end

  assign o_data    = r_data;
  assign o_ctrl    = r_ctrl;
  assign o_de      = r_de;
  assign o_locked  = r_locked;
  assign o_bitslip = r_bitslip;

endmodule

// File: tb/tb_tmds_decoder_dvi.sv
// Self-checking bench for tmds_decoder_dvi: scoreboard of expected outputs two
// cycles behind the driven symbols, plus a misaligned deserializer model.
module tb_tmds_decoder_dvi;

  localparam logic [9:0] T00  = 10'b1101010100;
  localparam logic [9:0] T01  = 10'b0010101011;
  localparam logic [9:0] T10  = 10'b0101010100;
  localparam logic [9:0] T11  = 10'b1010101011;
  localparam logic [9:0] IDLE = 10'h100;

  typedef struct {
    bit         chk;
    logic       locked;
    logic       de;
    logic [7:0] data;
    logic [1:0] ctrl;
    string      tag;
  } exp_t;

  logic       clk;
  logic       i_rst;
  logic [9:0] i_tmds;
  logic [7:0] o_data;
  logic [1:0] o_ctrl;
  logic       o_de;
  logic       o_locked;
  logic       o_bitslip;

  int         total;
  int         bad;
  exp_t       sb[$];
  logic [7:0] hold_data;
  logic [1:0] hold_ctrl;
  int         enc_cnt;
  bit         slip_prev;
  bit         slip_wide;

  tmds_decoder_dvi #(
    .SEARCH_LEN  (64),
    .SLIP_WAIT   (4),
    .LOCK_TOKENS (8),
    .LOSS_LIMIT  (32)
  ) dut (
    .i_clk     (clk),
    .i_rst     (i_rst),
    .i_tmds    (i_tmds),
    .o_data    (o_data),
    .o_ctrl    (o_ctrl),
    .o_de      (o_de),
    .o_locked  (o_locked),
    .o_bitslip (o_bitslip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A bit-slip request must never last longer than one cycle
  always @(negedge clk) begin
    if (o_bitslip && slip_prev) slip_wide = 1'b1;
    slip_prev = o_bitslip;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DVI transmitter reference: transition minimisation plus running-disparity balancing
  function automatic logic [9:0] tmds_enc(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1d, n1q, n0q;
    n1d   = $countones(d);
    qm[0] = d[0];
    if (n1d > 4 || (n1d == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8] == 1'b0) enc_cnt = enc_cnt + n0q - n1q;
      else               enc_cnt = enc_cnt + n1q - n0q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
    end
    return q;
  endfunction

  // Drive one symbol; outputs sampled now belong to the symbol driven two cycles ago
  task automatic send(input logic [9:0] sym, input exp_t e);
    exp_t x;
    @(negedge clk);
    if (sb.size() >= 2) begin
      x = sb.pop_front();
      if (x.chk) begin
        total++;
        if ({o_locked, o_de, o_data, o_ctrl} !== {x.locked, x.de, x.data, x.ctrl}) begin
          bad++;
          $display("FAIL %s: got locked=%b de=%b data=%h ctrl=%b, want locked=%b de=%b data=%h ctrl=%b",
                   x.tag, o_locked, o_de, o_data, o_ctrl, x.locked, x.de, x.data, x.ctrl);
        end
      end
    end
    i_tmds = sym;
    sb.push_back(e);
  endtask

  task automatic send_any(input logic [9:0] sym);
    exp_t e;
    e.chk = 1'b0; e.locked = 1'b0; e.de = 1'b0; e.data = '0; e.ctrl = '0; e.tag = "none";
    send(sym, e);
  endtask

  task automatic send_unl(input logic [9:0] sym, input string tag);
    exp_t e;
    hold_data = '0;
    hold_ctrl = '0;
    e.chk = 1'b1; e.locked = 1'b0; e.de = 1'b0; e.data = '0; e.ctrl = '0; e.tag = tag;
    send(sym, e);
  endtask

  task automatic send_tok(input logic [9:0] sym, input logic [1:0] c, input string tag);
    exp_t e;
    hold_ctrl = c;
    enc_cnt   = 0;
    e.chk = 1'b1; e.locked = 1'b1; e.de = 1'b0; e.data = hold_data; e.ctrl = c; e.tag = tag;
    send(sym, e);
  endtask

  task automatic send_dat(input logic [9:0] sym, input logic [7:0] b, input string tag);
    exp_t e;
    hold_data = b;
    e.chk = 1'b1; e.locked = 1'b1; e.de = 1'b1; e.data = b; e.ctrl = hold_ctrl; e.tag = tag;
    send(sym, e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_rst  = 1'b1;
    i_tmds = IDLE;
    sb.delete();
    hold_data = '0;
    hold_ctrl = '0;
    enc_cnt   = 0;
    #1;
    total++;
    if ({o_locked, o_bitslip, o_de, o_data, o_ctrl} !== 13'b0) begin
      bad++;
      $display("FAIL reset_state: got %b, want all zero", {o_locked, o_bitslip, o_de, o_data, o_ctrl});
    end
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    repeat (4) send_any(IDLE);
  endtask

  task automatic test_reset_lock();
    int slips;
    slips = 0;
    do_reset();
    for (int k = 1; k <= 7; k++) begin
      send_unl(T00, "prelock");
      if (o_bitslip) slips++;
    end
    send_tok(T00, 2'b00, "lock_8th_token");
    if (o_bitslip) slips++;
    for (int k = 0; k < 2; k++) begin
      send_tok(T00, 2'b00, "locked_ctrl00");
      if (o_bitslip) slips++;
    end
    total++;
    if (slips != 0) begin
      bad++;
      $display("FAIL no_slip_on_lock: got %0d bitslip pulses, want 0", slips);
    end
  endtask

  task automatic test_ctrl_tokens();
    send_tok(T01, 2'b01, "ctrl01");
    send_tok(T10, 2'b10, "ctrl10");
    send_tok(T11, 2'b11, "ctrl11");
    send_tok(T10, 2'b10, "ctrl10_again");
  endtask

  task automatic test_data();
    logic [7:0] b;
    send_dat(10'h100, 8'h00, "data_h100");
    send_dat(10'h200, 8'hFF, "data_h200");
    send_tok(T11, 2'b11, "ctrl_between_data");
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 6; k++) begin
        b = 8'($urandom_range(0, 255));
        send_dat(tmds_enc(b), b, "data_random");
      end
      send_tok(T00, 2'b00, "ctrl_blank");
    end
    b = 8'h00; send_dat(tmds_enc(b), b, "data_enc_00");
    b = 8'hFF; send_dat(tmds_enc(b), b, "data_enc_ff");
    send_any(T00);
    send_any(T00);
  endtask

  // Deserializer model: word taken at a bit offset into a stream of T00 tokens
  task automatic test_alignment();
    int offset, pulses, last, min_gap, cyc;
    bit dirty;
    logic [19:0] win;
    do_reset();
    offset = 3; pulses = 0; last = -1; min_gap = 1000000; cyc = 0; dirty = 1'b0;
    while (!o_locked && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (o_bitslip) begin
        pulses++;
        if (last >= 0 && (cyc - last) < min_gap) min_gap = cyc - last;
        last   = cyc;
        offset = (offset + 1) % 10;
      end
      if (!o_locked && (o_de || o_data != 8'h00 || o_ctrl != 2'b00)) dirty = 1'b1;
      win    = {T00, T00} >> offset;
      i_tmds = win[9:0];
    end
    total++;
    if (o_locked !== 1'b1) begin
      bad++;
      $display("FAIL align_lock: got locked=%b after %0d cycles, want 1", o_locked, cyc);
    end
    total++;
    if (pulses != 7) begin
      bad++;
      $display("FAIL align_slip_count: got %0d pulses, want 7", pulses);
    end
    total++;
    if (min_gap < 69) begin
      bad++;
      $display("FAIL align_slip_spacing: got min gap %0d, want >= 69", min_gap);
    end
    total++;
    if (dirty) begin
      bad++;
      $display("FAIL align_unlocked_zero: got nonzero outputs while unlocked, want zero");
    end
    total++;
    if (slip_wide) begin
      bad++;
      $display("FAIL slip_width: got bitslip high for 2+ cycles, want single cycle");
    end
    hold_data = '0;
    hold_ctrl = '0;
  endtask

  task automatic test_loss();
    logic [7:0] b;
    int drop, slip;
    enc_cnt = 0;
    for (int k = 1; k <= 31; k++) begin
      b = 8'($urandom_range(0, 255));
      send_dat(tmds_enc(b), b, "loss_still_locked");
    end
    b = 8'h5A;
    send_unl(tmds_enc(b), "loss_32nd_drops");
    drop = -1;
    slip = -1;
    for (int c = 0; c < 120 && slip < 0; c++) begin
      b = 8'($urandom_range(0, 255));
      send_unl(tmds_enc(b), "loss_unlocked_zero");
      if (drop < 0 && !o_locked) drop = c;
      if (drop >= 0 && o_bitslip) slip = c;
    end
    total++;
    if (drop < 0 || slip < 0 || (slip - drop) != 64) begin
      bad++;
      $display("FAIL loss_then_slip: got drop at %0d slip at %0d, want slip 64 cycles after drop", drop, slip);
    end
    total++;
    if (slip_wide) begin
      bad++;
      $display("FAIL slip_width_after_loss: got bitslip high for 2+ cycles, want single cycle");
    end
  endtask

  task automatic test_async_reset();
    bit found;
    test_reset_lock();
    send_dat(10'h200, 8'hFF, "pre_reset_data");
    send_any(T11);
    send_any(T11);
    total++;
    if ({o_locked, o_de, o_data} !== {1'b1, 1'b1, 8'hFF}) begin
      bad++;
      $display("FAIL pre_reset_active: got locked=%b de=%b data=%h, want 1 1 ff", o_locked, o_de, o_data);
    end
    #2;
    i_rst = 1'b1;
    #1;
    total++;
    if ({o_locked, o_bitslip, o_de, o_data, o_ctrl} !== 13'b0) begin
      bad++;
      $display("FAIL async_rst_locked: got %b, want all zero", {o_locked, o_bitslip, o_de, o_data, o_ctrl});
    end
    repeat (2) @(negedge clk);
    i_rst  = 1'b0;
    i_tmds = IDLE;
    sb.delete();
    found = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (o_bitslip) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL reach_slip: got no bitslip within 200 cycles, want one");
    end
    if (found) begin
      #2;
      i_rst = 1'b1;
      #1;
      total++;
      if ({o_locked, o_bitslip, o_de, o_data, o_ctrl} !== 13'b0) begin
        bad++;
        $display("FAIL async_rst_slip: got %b, want all zero", {o_locked, o_bitslip, o_de, o_data, o_ctrl});
      end
    end
    test_reset_lock();
    test_ctrl_tokens();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    slip_prev = 1'b0;
    slip_wide = 1'b0;
    i_rst     = 1'b1;
    i_tmds    = IDLE;
    test_reset_lock();
    test_ctrl_tokens();
    test_data();
    test_alignment();
    test_loss();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tmds_decoder_dvi.md
Name: tmds_decoder_dvi

Overview:
Receive-side counterpart of the DVI TMDS encoder: one instance per TMDS channel, fed 10-bit parallel symbols from the deserializer in the pixel clock domain. Finds word alignment by hunting for control tokens and pulsing a bit-slip request to the deserializer. Once locked, decodes each symbol back to 8-bit colour data, 2-bit control data and display enable, with fixed latency.

Parameters:
SEARCH_LEN, 4096, cycles in SEARCH without a qualifying token run before a bit-slip is requested; must exceed one video line period.
SLIP_WAIT, 16, cycles to ignore input after a bit-slip pulse while the deserializer settles.
LOCK_TOKENS, 8, consecutive valid control tokens needed to declare lock.
LOSS_LIMIT, 4096, cycles in LOCKED without any control token before lock is dropped.

Ports:
i_clk  in  1  pixel clock
i_rst  in  1  reset; asynchronous, active-high
i_tmds  in  10  raw TMDS symbol from the deserializer; bit 0 is the first bit on the wire
o_data  out  8  decoded colour data; valid when o_de=1
o_ctrl  out  2  decoded control data; {C1,C0}, i.e. {VSYNC,HSYNC} on the blue channel; valid when o_de=0
o_de  out  1  display enable; 1 = data period
o_locked  out  1  word alignment established
o_bitslip  out  1  one-cycle request to the deserializer to shift alignment by one bit

Behaviour:
- Reset (asynchronous assert, synchronous release): o_data=0, o_ctrl=0, o_de=0, o_locked=0, o_bitslip=0. All counters clear. FSM enters SEARCH. An assertion mid-operation aborts any state immediately.
- Pipeline: stage 1 registers i_tmds. Stage 2 registers the decoded outputs. Latency from i_tmds to o_data/o_ctrl/o_de is 2 cycles.
- Token detection (combinational on stage 1): 10'b1101010100 → 00, 10'b0010101011 → 01, 10'b0101010100 → 10, 10'b1010101011 → 11. Any other symbol is treated as data.
- Data decode:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - out[0] = d[0].
  - For i = 1..7: out[i] = q[8] ? d[i]^d[i-1] : d[i]~^d[i-1].
  - Examples: 10'h100 → 8'h00; 10'h200 → 8'hFF.
- Output qualification:
  - While o_locked=0: o_de=0, o_data=0, o_ctrl=0.
  - While locked:
    - token → o_de=0, o_ctrl=decoded value, o_data holds its previous value;
    - non-token → o_de=1, o_data=decoded value, o_ctrl holds its previous value.
- FSM states: SEARCH, SLIP, WAIT, LOCKED.
  - SEARCH:
    - Each cycle increments the search counter.
    - A token increments the run counter; a non-token clears it.
    - When the run counter reaches LOCK_TOKENS, go to LOCKED. This takes priority if it coincides with search-counter expiry.
    - When the search counter reaches SEARCH_LEN-1 without lock, go to SLIP.
  - SLIP: o_bitslip=1 for exactly this one cycle, then go to WAIT. o_bitslip is registered and never high outside SLIP.
  - WAIT:
    - Input is ignored for SLIP_WAIT cycles, then go to SEARCH.
    - Search and run counters are cleared on entry to SEARCH.
  - LOCKED:
    - o_locked=1.
    - Any token clears the loss counter; otherwise it increments.
    - When the loss counter reaches LOSS_LIMIT-1 with no token that cycle, go to SEARCH. o_locked falls on that transition edge and outputs are zero-qualified from the next cycle.
    - No slips are requested while locked.
- Slipping is unbounded: after 10 slips, alignment wraps back to the original phase and the search continues.
- Counter widths: $clog2(max value + 1). Counters saturate and never wrap.
- Lock is based on tokens only. Corrupt data symbols do not drop lock.

Decomposition:
- Shared package tmds_pkg holds:
  - the four control-token constants, shared with tmds_encoder_dvi;
  - the FSM state enumeration.
- One natural sub-module: tmds_symbol_decode. It is purely combinational, 10-bit in → 8-bit data, 2-bit ctrl, is_token. It is reusable and unit-testable apart from the alignment FSM.

Test Plan:
Bench uses SEARCH_LEN=64, SLIP_WAIT=4, LOCK_TOKENS=8, LOSS_LIMIT=32.
1. Reset, then 8 × 10'b1101010100 → o_locked rises on the clock edge on which the 8th token is registered (the edge after it is presented); from then o_de=0, o_ctrl=00. o_bitslip never pulses.
2. After lock: tokens 10'b0010101011, 10'b0101010100, 10'b1010101011 → o_ctrl = 01, 10, 11 two cycles after each input.
3. After lock: 10'h100 then 10'h200 → o_de=1, o_data = 8'h00 then 8'hFF, each 2 cycles after input. Also stream random bytes through a tmds_encoder_dvi model; bytes must match after 2 cycles.
4. Bench deserializer model starts 3 bits misaligned and rotates by one on each o_bitslip; stream contains token runs → exactly 7 single-cycle o_bitslip pulses at least 64+1+4 cycles apart, then lock.
5. Locked, then data symbols only for 32 cycles → o_locked falls; o_de=0, o_data=0 thereafter; FSM searches and pulses o_bitslip after 64 more cycles.
6. Assert i_rst asynchronously mid-LOCKED and mid-SLIP → all outputs 0 immediately, without a clock edge. Relock proceeds as in scenario 1 after release.
